// File: rtl/crc_lfsr_pipelined.sv
// Pipelined CRC generator/checker: STAGES-deep unfolded LFSR, each stage folds one message slice.
// Latency STAGES cycles; one global advance (adv) freezes every stage while out_valid && !out_ready.
module crc_lfsr_pipelined #(
  parameter int               MSG_W   = 10,
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = 8'h07,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int               STAGES  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MSG_W-1:0]       data_in,
  input  logic [CRC_W-1:0]       crc_in,
  input  logic                   check_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MSG_W+CRC_W-1:0] data_out,
  output logic [CRC_W-1:0]       crc_out,
  output logic                   crc_err
);

  localparam int CHUNK = (MSG_W + STAGES - 1) / STAGES;

  // Stage k folds message bits MSG_W-1-k*CHUNK downward; indices below 0 are skipped.
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] rem,
                                            input logic [MSG_W-1:0] msg,
                                            input int k);
    logic [CRC_W-1:0] r;
    logic [MSG_W-1:0] sh;
    logic             fb;
    int               idx;
    r = rem;
    for (int j = 0; j < CHUNK; j++) begin
      idx = MSG_W - 1 - k * CHUNK - j;
      if (idx >= 0) begin
        sh = msg >> idx;
        fb = r[CRC_W-1] ^ sh[0];
        r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      end
    end
    return r;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             c_vld  [STAGES];
  logic [CRC_W-1:0] c_rem  [STAGES];
  logic [MSG_W-1:0] c_msg  [STAGES];
  logic [CRC_W-1:0] c_crc  [STAGES];
  logic             c_mode [STAGES];

  assign c_vld[0]  = in_valid;
  assign c_rem[0]  = INIT;
  assign c_msg[0]  = data_in;
  assign c_crc[0]  = crc_in;
  assign c_mode[0] = check_mode;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CRC_W-1:0] rem_d;
    assign rem_d = fold(c_rem[k], c_msg[k], k);

    if (k < STAGES - 1) begin : g_mid
      logic             vld_q;
      logic [CRC_W-1:0] rem_q;
      logic [MSG_W-1:0] msg_q;
      logic [CRC_W-1:0] crc_q;
      logic             mode_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q  <= 1'b0;
          rem_q  <= '0;
          msg_q  <= '0;
          crc_q  <= '0;
          mode_q <= 1'b0;
        end else if (adv) begin
          vld_q  <= c_vld[k];
          rem_q  <= rem_d;
          msg_q  <= c_msg[k];
          crc_q  <= c_crc[k];
          mode_q <= c_mode[k];
        end
      end

      assign c_vld[k+1]  = vld_q;
      assign c_rem[k+1]  = rem_q;
      assign c_msg[k+1]  = msg_q;
      assign c_crc[k+1]  = crc_q;
      assign c_mode[k+1] = mode_q;
    end else begin : g_last
      // The final stage doubles as the output register, so latency stays at STAGES.
      logic             vld_q;
      logic             err_q;
      logic             err_d;
      logic [CRC_W-1:0] crc_q;
      logic [CRC_W-1:0] crc_d;
      logic [MSG_W-1:0] msg_q;

      assign crc_d = rem_d ^ XOR_OUT;
      assign err_d = c_mode[k] && (crc_d != c_crc[k]);

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q <= 1'b0;
          err_q <= 1'b0;
          crc_q <= '0;
          msg_q <= '0;
        end else if (adv) begin
          vld_q <= c_vld[k];
          err_q <= err_d;
          crc_q <= crc_d;
          msg_q <= c_msg[k];
        end
      end

      assign out_valid = vld_q;
      assign crc_out   = crc_q;
      assign data_out  = {msg_q, crc_q};
      assign crc_err   = err_q;
    end
  end

endmodule

// File: tb/tb_crc_lfsr_pipelined.sv
// Bench: DUT 0 is the default 10/8-bit block; DUTs 1..3 are 16/16-bit (POLY 1021, INIT FFFF)
// with STAGES 1, 3 and 16, all scored against a bit-serial reference and a frame-timing model.
module tb_crc_lfsr_pipelined;

  localparam int STG_T [4] = '{4, 1, 3, 16};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vin   [4];
  logic        mode  [4];
  logic        ordy  [4];
  logic [15:0] din   [4];
  logic [15:0] crcin [4];

  wire         ovld  [4];
  wire         irdy  [4];
  wire         err   [4];
  wire  [31:0] crco  [4];
  wire  [31:0] dout  [4];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  wire [17:0] d0_dout;
  wire [7:0]  d0_crc;
  assign dout[0] = {14'b0, d0_dout};
  assign crco[0] = {24'b0, d0_crc};

  crc_lfsr_pipelined #(
    .MSG_W(10), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .STAGES(4)
  ) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(vin[0]), .in_ready(irdy[0]),
    .data_in(din[0][9:0]), .crc_in(crcin[0][7:0]), .check_mode(mode[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .data_out(d0_dout),
    .crc_out(d0_crc), .crc_err(err[0])
  );

  for (genvar g = 1; g < 4; g++) begin : g_dut
    wire [15:0] c16;
    assign crco[g] = {16'b0, c16};
    crc_lfsr_pipelined #(
      .MSG_W(16), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
      .STAGES(STG_T[g])
    ) u_dut (
      .clk(clk), .reset(reset), .in_valid(vin[g]), .in_ready(irdy[g]),
      .data_in(din[g]), .crc_in(crcin[g]), .check_mode(mode[g]),
      .out_valid(ovld[g]), .out_ready(ordy[g]), .data_out(dout[g]),
      .crc_out(c16), .crc_err(err[g])
    );
  end

  function automatic int mw_of(int d);
    return (d == 0) ? 10 : 16;
  endfunction

  function automatic logic [31:0] ref_crc(int d, logic [31:0] msg);
    int          cw;
    logic [31:0] poly, r, mask;
    logic        fb;
    cw   = (d == 0) ? 8 : 16;
    poly = (d == 0) ? 32'h07 : 32'h1021;
    r    = (d == 0) ? 32'h0 : 32'hFFFF;
    mask = (32'd1 << cw) - 32'd1;
    for (int i = mw_of(d) - 1; i >= 0; i--) begin
      fb = r[cw-1] ^ msg[i];
      r  = ((r << 1) ^ (fb ? poly : 32'd0)) & mask;
    end
    return r;
  endfunction

  function automatic logic [31:0] msg_mask(int d);
    return (32'd1 << mw_of(d)) - 32'd1;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] crc;
    logic [31:0] data;
    logic        err;
    int          a;
  } exp_t;

  exp_t sbq [4][$];
  int   tk  [4];
  exp_t m_e;
  logic m_ev;
  logic [31:0] m_msg;

  // A frame accepted on advancing edge number a sits in the output register while a+STAGES-1 edges have advanced.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 4; d++) begin
        while (sbq[d].size() > 0 && sbq[d][0].a < tk[d] - (STG_T[d] - 1))
          void'(sbq[d].pop_front());
        m_ev = sbq[d].size() > 0 && sbq[d][0].a == tk[d] - (STG_T[d] - 1);
        chk("out_valid", d, {31'b0, ovld[d]}, {31'b0, m_ev});
        chk("in_ready", d, {31'b0, irdy[d]}, {31'b0, !m_ev || ordy[d]});
        if (m_ev) begin
          chk("crc_out", d, crco[d], sbq[d][0].crc);
          chk("data_out", d, dout[d], sbq[d][0].data);
          chk("crc_err", d, {31'b0, err[d]}, {31'b0, sbq[d][0].err});
        end
        if (reset) begin
          sbq[d].delete();
        end else if (!m_ev || ordy[d]) begin
          tk[d]++;
          if (vin[d]) begin
            m_msg    = {16'b0, din[d]} & msg_mask(d);
            m_e.crc  = ref_crc(d, m_msg);
            m_e.data = (m_msg << ((d == 0) ? 8 : 16)) | m_e.crc;
            m_e.err  = mode[d] && (m_e.crc != ({16'b0, crcin[d]} & ((d == 0) ? 32'hFF : 32'hFFFF)));
            m_e.a    = tk[d];
            sbq[d].push_back(m_e);
          end
        end
      end
    end
  end

  task automatic drv_idle();
    for (int d = 0; d < 4; d++) begin
      vin[d] = 1'b0; mode[d] = 1'b0; ordy[d] = 1'b1; din[d] = '0; crcin[d] = '0;
    end
  endtask

  task automatic send(input int d, input logic [15:0] m, input logic md, input logic [15:0] c);
    @(posedge clk); #1;
    vin[d] = 1'b1; din[d] = m; mode[d] = md; crcin[d] = c;
  endtask

  task automatic stop(input int d);
    @(posedge clk); #1;
    vin[d] = 1'b0;
  endtask

  task automatic lat_test(input int d, input logic [15:0] m, output int n);
    send(d, m, 1'b0, 16'h0);
    stop(d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ovld[d] && n < 40);
    chk("latency", d, n, STG_T[d]);
  endtask

  logic [31:0] got_c [3];
  logic        got_e [3];
  int          got_t [3];
  int          n, cnt, seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drv_idle();
    for (int d = 0; d < 4; d++) tk[d] = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    chk("model_303", 0, ref_crc(0, 32'h303), 32'h36);
    chk("model_001", 0, ref_crc(0, 32'h001), 32'h07);
    chk("model_000", 0, ref_crc(0, 32'h000), 32'h00);

    @(negedge clk);
    chk("rst_out_valid", 0, {31'b0, ovld[0]}, 32'h0);
    chk("rst_data_out", 0, dout[0], 32'h0);
    chk("rst_crc_out", 0, crco[0], 32'h0);
    chk("rst_crc_err", 0, {31'b0, err[0]}, 32'h0);
    chk("rst_in_ready", 0, {31'b0, irdy[0]}, 32'h1);

    lat_test(0, 16'h303, n);
    chk("gen_crc", 0, crco[0], 32'h36);
    chk("gen_data", 0, dout[0], 32'h30336);
    chk("gen_err", 0, {31'b0, err[0]}, 32'h0);

    send(0, 16'h000, 1'b0, 16'h0);
    send(0, 16'h001, 1'b0, 16'h0);
    send(0, 16'h303, 1'b0, 16'h0);
    stop(0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ovld[0] && cnt < 3) begin
        got_c[cnt] = crco[0]; got_t[cnt] = i; cnt++;
      end
    end
    chk("b2b_count", 0, cnt, 3);
    chk("b2b_c0", 0, got_c[0], 32'h00);
    chk("b2b_c1", 0, got_c[1], 32'h07);
    chk("b2b_c2", 0, got_c[2], 32'h36);
    chk("b2b_span", 0, got_t[2] - got_t[0], 2);

    @(posedge clk); #1;
    ordy[0] = 1'b0;
    send(0, 16'h303, 1'b0, 16'h0);
    send(0, 16'h001, 1'b0, 16'h0);
    stop(0);
    n = 0;
    while (!ovld[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_rise", 0, {31'b0, ovld[0]}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_crc", 0, crco[0], 32'h36);
      chk("bp_in_ready", 0, {31'b0, irdy[0]}, 32'h0);
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_crc", 0, crco[0], 32'h36);
    @(negedge clk);
    chk("bp_next_valid", 0, {31'b0, ovld[0]}, 32'h1);
    chk("bp_next_crc", 0, crco[0], 32'h07);
    @(negedge clk);
    chk("bp_drained", 0, {31'b0, ovld[0]}, 32'h0);

    send(0, 16'h303, 1'b1, 16'h36);
    send(0, 16'h303, 1'b1, 16'h37);
    stop(0);
    mode[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ovld[0] && cnt < 2) begin
        got_c[cnt] = crco[0]; got_e[cnt] = err[0]; cnt++;
      end
    end
    chk("chk_count", 0, cnt, 2);
    chk("chk_ok_err", 0, {31'b0, got_e[0]}, 32'h0);
    chk("chk_bad_err", 0, {31'b0, got_e[1]}, 32'h1);
    chk("chk_ok_crc", 0, got_c[0], 32'h36);
    chk("chk_bad_crc", 0, got_c[1], 32'h36);

    send(0, 16'h303, 1'b0, 16'h0);
    send(0, 16'h001, 1'b0, 16'h0);
    stop(0);
    din[0] = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_data_out", 0, dout[0], 32'h0);
    chk("rmid_crc_out", 0, crco[0], 32'h0);
    chk("rmid_crc_err", 0, {31'b0, err[0]}, 32'h0);
    seen = ovld[0] ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ovld[0]) seen++;
    end
    chk("rmid_no_valid", 0, seen, 0);
    lat_test(0, 16'h001, n);
    chk("rmid_new_crc", 0, crco[0], 32'h07);

    for (int d = 1; d < 4; d++) lat_test(d, 16'($urandom), n);

    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        vin[d]  = ($urandom_range(2) != 0);
        din[d]  = 16'($urandom);
        mode[d] = $urandom_range(1) != 0;
        ordy[d] = ($urandom_range(3) != 0);
        crcin[d] = ($urandom_range(1) != 0) ? 16'(ref_crc(d, {16'b0, din[d]} & msg_mask(d)))
                                            : 16'($urandom);
      end
    end
    @(posedge clk); #1;
    drv_idle();
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
